// File: rtl/ethernet_pkg.sv
// Shared types and constants for the Ethernet management (MDIO) block.
package ethernet_pkg;

    typedef enum logic [1:0] {
        MDIO_WRITE = 2'b01,
        MDIO_READ  = 2'b10
    } mdio_opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        TURNAROUND,
        DATA,
        DONE
    } mdio_state_t;

    localparam logic [1:0]  MDIO_START         = 2'b01;
    localparam int unsigned MDIO_PREAMBLE_BITS = 32;
    localparam int unsigned MDIO_HEADER_BITS   = 14;
    localparam int unsigned MDIO_TA_BITS       = 2;
    localparam int unsigned MDIO_DATA_BITS     = 16;

    // ST, OP, PHYAD, REGAD in transmit order, MSB first.
    function automatic logic [13:0] mdio_header(input mdio_opcode_t op,
                                                input logic [4:0]   phyad,
                                                input logic [4:0]   regad);
        return {MDIO_START, op, phyad, regad};
    endfunction

    // Bit counter load value for a field of n bits (counts down to zero).
    function automatic logic [4:0] mdio_last_bit(input int unsigned n);
        return 5'(n - 1);
    endfunction

endpackage

// File: rtl/mdio_clock_generator.sv
// MDC generator: one bit lasts 2*HALF_PERIOD cycles, MDC low for the first half.
// Held at counter zero with MDC low whenever enable_i is low.
module mdio_clock_generator #(
    parameter int unsigned HALF_PERIOD = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    output logic mdc_o,
    output logic sample_o,
    output logic bit_start_o
);

    localparam int unsigned BIT_CYCLES = 2 * HALF_PERIOD;
    localparam int unsigned CW         = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] LAST_AT   = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdc_q, mdc_d;

    // sample_o marks the edge where MDC rises; bit_start_o marks the edge where
    // MDC falls and the following bit begins.
    always_comb begin
        sample_o    = enable_i && (cnt_q == SAMPLE_AT);
        bit_start_o = enable_i && (cnt_q == LAST_AT);
        cnt_d       = '0;
        mdc_d       = 1'b0;
        if (enable_i) begin
            cnt_d = bit_start_o ? '0 : cnt_q + CW'(1);
            if (sample_o) begin
                mdc_d = 1'b1;
            end else if (bit_start_o) begin
                mdc_d = 1'b0;
            end else begin
                mdc_d = mdc_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc_o = mdc_q;

endmodule

// File: rtl/ethernet_mdio_controller.sv
// Clause-22 MDIO master: one register read or write per request, done pulse on completion.
// Build option ETH_MDIO_PREAMBLE_SUPPRESS_EN: preamble only on the first frame after reset.
module ethernet_mdio_controller
    import ethernet_pkg::*;
#(
    parameter int unsigned SYSTEM_CLOCK  = 100_000_000,
    parameter int unsigned MDC_FREQUENCY = 2_500_000,
    parameter logic [4:0]  PHY_ADDRESS   = 5'b00001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  address_i,
    input  logic        write_i,
    input  logic        read_i,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    output logic        done_o,
    output logic        error_o,
    output logic        busy_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i,
    input  logic        phy_interrupt_n_i,
    output logic        interrupt_o
);

    localparam int unsigned HALF_PERIOD = SYSTEM_CLOCK / (2 * MDC_FREQUENCY);

    mdio_state_t  state_q, state_d;
    logic [4:0]   bit_cnt_q, bit_cnt_d;
    mdio_opcode_t op_q, op_d;
    logic [4:0]   addr_q, addr_d;
    logic [15:0]  wdata_q, wdata_d;
    logic [15:0]  rx_q, rx_d;
    logic         ta_err_q, ta_err_d;
    logic [15:0]  data_q, data_d;
    logic         irq_meta_q, irq_sync_q;
    logic         clk_en, sample, bit_start;
    logic         last_bit;
    logic [13:0]  header;
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
    logic         preamble_sent_q, preamble_sent_d;
`endif

    assign clk_en   = (state_q != IDLE) && (state_q != DONE);
    assign last_bit = (bit_cnt_q == 5'd0);
    assign header   = mdio_header(op_q, PHY_ADDRESS, addr_q);

    mdio_clock_generator #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_clock_generator (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (clk_en),
        .mdc_o       (mdc_o),
        .sample_o    (sample),
        .bit_start_o (bit_start)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        ta_err_d  = ta_err_q;
        data_d    = data_q;
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
        preamble_sent_d = preamble_sent_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (write_i || read_i) begin
                    // A simultaneous write and read performs the write.
                    op_d     = write_i ? MDIO_WRITE : MDIO_READ;
                    addr_d   = address_i;
                    wdata_d  = data_i;
                    ta_err_d = 1'b0;
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
                    if (preamble_sent_q) begin
                        state_d   = HEADER;
                        bit_cnt_d = mdio_last_bit(MDIO_HEADER_BITS);
                    end else begin
                        state_d   = PREAMBLE;
                        bit_cnt_d = mdio_last_bit(MDIO_PREAMBLE_BITS);
                    end
`else
                    state_d   = PREAMBLE;
                    bit_cnt_d = mdio_last_bit(MDIO_PREAMBLE_BITS);
`endif
                end
            end
            PREAMBLE: begin
                if (bit_start) begin
                    if (last_bit) begin
                        state_d   = HEADER;
                        bit_cnt_d = mdio_last_bit(MDIO_HEADER_BITS);
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
                        preamble_sent_d = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            HEADER: begin
                if (bit_start) begin
                    if (last_bit) begin
                        state_d   = TURNAROUND;
                        bit_cnt_d = mdio_last_bit(MDIO_TA_BITS);
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            TURNAROUND: begin
                // A PHY that answers pulls the second TA bit low.
                if (sample && last_bit && (op_q == MDIO_READ)) begin
                    ta_err_d = mdio_i;
                end
                if (bit_start) begin
                    if (last_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = mdio_last_bit(MDIO_DATA_BITS);
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            DATA: begin
                if (sample && (op_q == MDIO_READ)) begin
                    rx_d = {rx_q[14:0], mdio_i};
                end
                if (bit_start) begin
                    if (last_bit) begin
                        state_d = DONE;
                        if (op_q == MDIO_READ) begin
                            data_d = ta_err_q ? 16'hFFFF : rx_q;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= 5'd0;
            op_q      <= MDIO_WRITE;
            addr_q    <= 5'd0;
            wdata_q   <= 16'd0;
            rx_q      <= 16'd0;
            ta_err_q  <= 1'b0;
            data_q    <= 16'd0;
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
            preamble_sent_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            ta_err_q  <= ta_err_d;
            data_q    <= data_d;
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
            preamble_sent_q <= preamble_sent_d;
`endif
        end
    end

    // Pin drive follows state and bit counter, so it changes exactly at bit start.
    always_comb begin
        mdio_o    = 1'b1;
        mdio_oe_o = 1'b0;
        unique case (state_q)
            PREAMBLE: begin
                mdio_oe_o = 1'b1;
            end
            HEADER: begin
                mdio_oe_o = 1'b1;
                mdio_o    = header[bit_cnt_q[3:0]];
            end
            TURNAROUND: begin
                if (op_q == MDIO_WRITE) begin
                    mdio_oe_o = 1'b1;
                    mdio_o    = bit_cnt_q[0];
                end
            end
            DATA: begin
                if (op_q == MDIO_WRITE) begin
                    mdio_oe_o = 1'b1;
                    mdio_o    = wdata_q[bit_cnt_q[3:0]];
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_meta_q <= 1'b0;
            irq_sync_q <= 1'b0;
        end else begin
            irq_meta_q <= ~phy_interrupt_n_i;
            irq_sync_q <= irq_meta_q;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign error_o     = done_o && (op_q == MDIO_READ) && ta_err_q;
    assign data_o      = data_q;
    assign interrupt_o = irq_sync_q;

endmodule

// File: tb/tb_ethernet_mdio_controller.sv
// Self-checking bench for ethernet_mdio_controller with a behavioural PHY and frame model.
module tb_ethernet_mdio_controller;

    localparam int BIT_CYCLES = 40;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [4:0]  address_i;
    logic        write_i;
    logic        read_i;
    logic [15:0] data_i;
    logic [15:0] data_o;
    logic        done_o;
    logic        error_o;
    logic        busy_o;
    logic        mdc_o;
    logic        mdio_o;
    logic        mdio_oe_o;
    logic        mdio_i = 1'b1;
    logic        phy_interrupt_n_i;
    logic        interrupt_o;

    always #5 clk = ~clk;

    ethernet_mdio_controller dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .address_i         (address_i),
        .write_i           (write_i),
        .read_i            (read_i),
        .data_i            (data_i),
        .data_o            (data_o),
        .done_o            (done_o),
        .error_o           (error_o),
        .busy_o            (busy_o),
        .mdc_o             (mdc_o),
        .mdio_o            (mdio_o),
        .mdio_oe_o         (mdio_oe_o),
        .mdio_i            (mdio_i),
        .phy_interrupt_n_i (phy_interrupt_n_i),
        .interrupt_o       (interrupt_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // PHY model configuration, written only by the stimulus process.
    logic        phy_read    = 1'b0;
    logic        phy_present = 1'b1;
    logic [15:0] phy_resp    = 16'h0;
    int          pre_len     = 32;

    // PHY model state, written only by the PHY process.
    int   phy_bit  = 0;
    int   oe_viol  = 0;
    logic prev_mdc = 1'b0;
    logic rec_oe  [64];
    logic rec_val [64];

    function automatic logic phy_drive(input int k);
        int j;
        j = k - pre_len;
        if (!phy_read) return 1'b1;
        if (j == 15) return !phy_present;
        if (j >= 16 && j < 32) return phy_present ? phy_resp[31-j] : 1'b1;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        int cur;
        if (busy_o !== 1'b1) begin
            phy_bit = 0;
            mdio_i  = 1'b1;
        end else begin
            if (mdc_o && !prev_mdc) begin
                if (phy_bit < 64) begin
                    rec_oe[phy_bit]  = mdio_oe_o;
                    rec_val[phy_bit] = mdio_o;
                end
                phy_bit++;
            end
            if (!mdc_o && prev_mdc) mdio_i = phy_drive(phy_bit);
            cur = mdc_o ? phy_bit - 1 : phy_bit;
            if (phy_read && cur >= pre_len + 14 && cur < pre_len + 32 && mdio_oe_o) oe_viol++;
        end
        prev_mdc = mdc_o;
    end

    // Expected frame content, built directly from the clause-22 field layout.
    function automatic logic exp_bit(input int i, input logic wr, input logic [4:0] addr,
                                     input logic [15:0] wdata, input int pre);
        logic [13:0] hdr;
        int j;
        hdr = {2'b01, (wr ? 2'b01 : 2'b10), 5'b00001, addr};
        if (i < pre) return 1'b1;
        j = i - pre;
        if (j < 14) return hdr[13-j];
        if (j == 14) return 1'b1;
        if (j == 15) return 1'b0;
        return wdata[31-j];
    endfunction

    logic        first_frame = 1'b1;
    logic [15:0] model_data  = 16'h0;

    task automatic run_frame(input string name, input logic wr, input logic rd,
                             input logic [4:0] addr, input logic [15:0] wdata,
                             input logic [15:0] resp, input logic present, input logic inject,
                             input logic [15:0] exp_data, input logic exp_err);
        int   pre, cyc, extra, bit_err, viol0, len;
        logic got_done;
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
        pre = first_frame ? 32 : 0;
`else
        pre = 32;
`endif
        len         = pre + 32;
        phy_read    = !wr;
        phy_present = present;
        phy_resp    = resp;
        pre_len     = pre;
        viol0       = oe_viol;
        @(negedge clk);
        write_i   = wr;
        read_i    = rd;
        address_i = addr;
        data_i    = wdata;
        @(posedge clk);
        #1;
        write_i   = 1'b0;
        read_i    = 1'b0;
        address_i = 5'($urandom);
        data_i    = 16'($urandom);
        chk({name, "_busy_start"}, 32'(busy_o), 32'd1);
        cyc      = 1;
        got_done = 1'b0;
        while (!got_done && cyc <= 3000) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                got_done = 1'b1;
            end else begin
                read_i = (inject && cyc == 100);
                cyc++;
            end
        end
        read_i = 1'b0;
        chk({name, "_latency"}, 32'(cyc), 32'(1 + BIT_CYCLES * len));
        if (got_done) begin
            chk({name, "_data"}, 32'(data_o), 32'(exp_data));
            chk({name, "_error"}, 32'(error_o), 32'(exp_err));
            chk({name, "_bits_seen"}, 32'(phy_bit), 32'(len));
            bit_err = 0;
            for (int i = 0; i < len; i++) begin
                if (i < pre + 14 || wr) begin
                    if (rec_oe[i] !== 1'b1 ||
                        rec_val[i] !== exp_bit(i, wr, addr, wdata, pre)) bit_err++;
                end else if (rec_oe[i] !== 1'b0) begin
                    bit_err++;
                end
            end
            chk({name, "_frame_bits"}, 32'(bit_err), 32'd0);
            if (!wr) chk({name, "_oe_tail"}, 32'(oe_viol - viol0), 32'd0);
            extra = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done_o !== 1'b0) extra++;
            end
            chk({name, "_single_done"}, 32'(extra), 32'd0);
            chk({name, "_idle_after"}, {30'd0, busy_o, mdc_o}, 32'd0);
            chk({name, "_data_hold"}, 32'(data_o), 32'(exp_data));
            first_frame = 1'b0;
        end
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] resp;
        logic        present;
        logic        inject;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int   cyc, dones;
        logic wr, rd, present;
        logic [4:0]  addr;
        logic [15:0] wdata, resp, exp_d;

        vecs[0] = '{1'b1, 1'b0, 5'h00, 16'h1200, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 5'h01, 16'h0000, 16'h796D, 1'b1, 1'b0, 16'h796D, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 5'h02, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 5'h03, 16'hBEEF, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'h1F, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 5'h1F, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0};

        rst_i = 1'b1; write_i = 1'b0; read_i = 1'b0; address_i = '0; data_i = '0;
        phy_interrupt_n_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_done_err_busy", {29'd0, done_o, error_o, busy_o}, 32'd0);
        chk("rst_mdc", 32'(mdc_o), 32'd0);
        chk("rst_mdio", {30'd0, mdio_o, mdio_oe_o}, 32'd2);
        chk("rst_irq", 32'(interrupt_o), 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].wr, vecs[v].rd, vecs[v].addr,
                      vecs[v].wdata, vecs[v].resp, vecs[v].present, vecs[v].inject,
                      vecs[v].exp_data, vecs[v].exp_err);
        end

        // Reset 1000 cycles into a write frame.
        @(negedge clk);
        write_i = 1'b1; address_i = 5'h04; data_i = 16'hA5A5;
        phy_read = 1'b0;
        @(posedge clk);
        #1;
        write_i = 1'b0;
        for (cyc = 1; cyc < 1000; cyc++) @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("abort_outputs", {29'd0, mdc_o, mdio_oe_o, busy_o}, 32'd0);
        dones = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_o !== 1'b0) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        first_frame = 1'b1;
        model_data  = 16'h0000;
        run_frame("post_abort_read", 1'b0, 1'b1, 5'h01, 16'h0, 16'h5A3C, 1'b1, 1'b0,
                  16'h5A3C, 1'b0);
        model_data = 16'h5A3C;

        for (int n = 0; n < 5; n++) begin
            wr      = 1'($urandom);
            rd      = wr ? 1'($urandom) : 1'b1;
            addr    = 5'($urandom);
            wdata   = 16'($urandom);
            resp    = 16'($urandom);
            present = ($urandom_range(3) != 0);
            exp_d   = wr ? model_data : (present ? resp : 16'hFFFF);
            run_frame($sformatf("rand%0d", n), wr, rd, addr, wdata, resp, present, 1'b0,
                      exp_d, !wr && !present);
            model_data = exp_d;
        end

        @(negedge clk);
        phy_interrupt_n_i = 1'b0;
        @(posedge clk); #1;
        chk("irq_assert_1cyc", 32'(interrupt_o), 32'd0);
        @(posedge clk); #1;
        chk("irq_assert_2cyc", 32'(interrupt_o), 32'd1);
        @(negedge clk);
        phy_interrupt_n_i = 1'b1;
        @(posedge clk); #1;
        chk("irq_release_1cyc", 32'(interrupt_o), 32'd1);
        @(posedge clk); #1;
        chk("irq_release_2cyc", 32'(interrupt_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

endmodule
